// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared IDs, size encodings and helpers for the SRAM bus arbiter
package sram_arb_pkg;

  typedef logic [0:0] arb_id_t;

  localparam arb_id_t ID_INST = 1'b0;
  localparam arb_id_t ID_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  function automatic arb_id_t other_id(input arb_id_t id);
    return (id == ID_INST) ? ID_DATA : ID_INST;
  endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// rtl/arb_id_fifo.sv - outstanding-ID FIFO: records which requester owns each in-flight transaction
module arb_id_fifo
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    resetn,
  input  logic    i_push,
  input  arb_id_t i_din,
  input  logic    i_pop,
  output logic    o_full,
  output logic    o_empty,
  output arb_id_t o_head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  arb_id_t       r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  // Guard internally so a misbehaving caller can never corrupt the count.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - shares one SRAM-like port between inst and data requesters;
// define ARB_ROUND_ROBIN_EN for round-robin arbitration, otherwise data has fixed priority
module sram_bus_arbiter
  import sram_arb_pkg::*;
#(
  parameter int MAX_OUTST = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic        err_unexp_rsp
);

  logic    r_lock_valid;
  arb_id_t r_lock_id;
  logic    r_err;
`ifdef ARB_ROUND_ROBIN_EN
  arb_id_t r_rr_ptr;
`endif

  arb_id_t w_winner;
  logic    w_winner_req;
  logic    w_handshake;
  logic    w_rsp;
  logic    w_full;
  logic    w_empty;
  arb_id_t w_head;

  always_comb begin
    w_winner = ID_INST;
    if (r_lock_valid) begin
      w_winner = r_lock_id;
    end else if (data_req && inst_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      w_winner = r_rr_ptr;
`else
      w_winner = ID_DATA;
`endif
    end else if (data_req) begin
      w_winner = ID_DATA;
    end
  end

  assign w_winner_req = (w_winner == ID_DATA) ? data_req : inst_req;

  // Gated by resetn so every request-side output is quiet while reset is held.
  assign mem_req     = resetn & w_winner_req & ~w_full;
  assign w_handshake = mem_req & mem_addr_ok;

  always_comb begin
    mem_wr    = inst_wr;
    mem_size  = inst_size;
    mem_wstrb = inst_wstrb;
    mem_addr  = inst_addr;
    mem_wdata = inst_wdata;
    if (w_winner == ID_DATA) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end
  end

  assign inst_addr_ok = w_handshake & (w_winner == ID_INST);
  assign data_addr_ok = w_handshake & (w_winner == ID_DATA);

  assign w_rsp        = resetn & mem_data_ok & ~w_empty;
  assign inst_data_ok = w_rsp & (w_head == ID_INST);
  assign data_data_ok = w_rsp & (w_head == ID_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  assign err_unexp_rsp = r_err;

  arb_id_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_handshake),
    .i_din   (w_winner),
    .i_pop   (w_rsp),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // A stalled address phase pins the grant so the payload cannot change under the memory.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lock_valid <= 1'b0;
      r_lock_id    <= ID_INST;
    end else if (w_handshake) begin
      r_lock_valid <= 1'b0;
    end else if (mem_req) begin
      r_lock_valid <= 1'b1;
      r_lock_id    <= w_winner;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rr_ptr <= ID_INST;
    end else if (w_handshake) begin
      r_rr_ptr <= other_id(w_winner);
    end
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err <= 1'b0;
    end else if (mem_data_ok && w_empty) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb/tb_sram_bus_arbiter.sv - directed self-checking bench for sram_bus_arbiter
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, mem_size;
  logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        err_unexp_rsp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.MAX_OUTST(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .err_unexp_rsp(err_unexp_rsp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic clear_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0;
    inst_addr = 32'h0; inst_wdata = 32'h0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 0;
    tick();
    tick();
    resetn = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    resetn = 0;
    tick();
    settle();
    checks++;
    if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, err_unexp_rsp} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=000000",
               {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, err_unexp_rsp});
    end
    resetn = 1;
    tick();
  endtask

  task automatic test_inst_reads();
    logic [31:0] addrs [3];
    logic [31:0] rds [3];
    int rsp;
    addrs[0] = 32'h1000; addrs[1] = 32'h1004; addrs[2] = 32'h1008;
    rds[0] = 32'hA0A0_0001; rds[1] = 32'hA0A0_0002; rds[2] = 32'hA0A0_0003;
    do_reset();
    rsp = 0;
    for (int c = 0; c < 5; c++) begin
      inst_req    = (c < 3);
      inst_addr   = (c < 3) ? addrs[c] : 32'h0;
      mem_addr_ok = 1;
      mem_data_ok = (c >= 2);
      mem_rdata   = (c >= 2) ? rds[c-2] : 32'h0;
      settle();
      if (c < 3) begin
        checks++;
        if (mem_req !== 1'b1 || inst_addr_ok !== 1'b1 || mem_addr !== addrs[c]) begin
          errors++;
          $display("FAIL inst_read_addr c=%0d req=%b aok=%b addr=%h want 1/1/%h",
                   c, mem_req, inst_addr_ok, mem_addr, addrs[c]);
        end
      end
      if (c >= 2) begin
        checks++;
        if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== rds[c-2]) begin
          errors++;
          $display("FAIL inst_read_rsp c=%0d iok=%b dok=%b rdata=%h want 1/0/%h",
                   c, inst_data_ok, data_data_ok, inst_rdata, rds[c-2]);
        end
      end
      tick();
    end
    clear_inputs();
    settle();
    checks++;
    if (inst_data_ok !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL inst_read_idle iok=%b req=%b want 0/0", inst_data_ok, mem_req);
    end
    tick();
  endtask

  task automatic test_priority();
    logic first_data;
`ifdef ARB_ROUND_ROBIN_EN
    first_data = 1'b0;
`else
    first_data = 1'b1;
`endif
    do_reset();
    inst_req = 1; inst_addr = 32'h100;
    data_req = 1; data_addr = 32'h200; data_wr = 1; data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF;
    mem_addr_ok = 1;
    settle();
    checks++;
    if (data_addr_ok !== first_data || inst_addr_ok !== ~first_data ||
        mem_addr !== (first_data ? 32'h200 : 32'h100)) begin
      errors++;
      $display("FAIL prio_first daok=%b iaok=%b addr=%h want data_first=%b",
               data_addr_ok, inst_addr_ok, mem_addr, first_data);
    end
    if (first_data) begin
      checks++;
      if (mem_wr !== 1'b1 || mem_wstrb !== 4'hF || mem_wdata !== 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL prio_payload wr=%b wstrb=%h wdata=%h want 1/f/deadbeef", mem_wr, mem_wstrb, mem_wdata);
      end
    end
    tick();
    if (first_data) data_req = 0; else inst_req = 0;
    settle();
    checks++;
    if (data_addr_ok !== ~first_data || inst_addr_ok !== first_data) begin
      errors++;
      $display("FAIL prio_second daok=%b iaok=%b want data_first=%b", data_addr_ok, inst_addr_ok, first_data);
    end
    tick();
    inst_req = 0; data_req = 0; mem_addr_ok = 0;
    mem_data_ok = 1; mem_rdata = 32'h11;
    settle();
    checks++;
    if (data_data_ok !== first_data || inst_data_ok !== ~first_data || data_rdata !== 32'h11) begin
      errors++;
      $display("FAIL prio_rsp1 dok=%b iok=%b rdata=%h want data_first=%b rdata=11",
               data_data_ok, inst_data_ok, data_rdata, first_data);
    end
    tick();
    mem_rdata = 32'h22;
    settle();
    checks++;
    if (data_data_ok !== ~first_data || inst_data_ok !== first_data || inst_rdata !== 32'h22) begin
      errors++;
      $display("FAIL prio_rsp2 dok=%b iok=%b rdata=%h want data_first=%b rdata=22",
               data_data_ok, inst_data_ok, inst_rdata, first_data);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_data;
`ifdef ARB_ROUND_ROBIN_EN
    exp_data = 4'b1010;
`else
    exp_data = 4'b1111;
`endif
    do_reset();
    inst_req = 1; inst_addr = 32'h300;
    data_req = 1; data_addr = 32'h400;
    mem_addr_ok = 1;
    for (int c = 0; c < 4; c++) begin
      settle();
      checks++;
      if (data_addr_ok !== exp_data[c] || inst_addr_ok !== ~exp_data[c]) begin
        errors++;
        $display("FAIL rr_grant c=%0d daok=%b iaok=%b want daok=%b", c, data_addr_ok, inst_addr_ok, exp_data[c]);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_lock();
    do_reset();
    inst_req = 1; inst_addr = 32'h500;
    data_addr = 32'h600;
    for (int c = 0; c < 3; c++) begin
      data_req = (c >= 1);
      mem_addr_ok = 0;
      settle();
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h500 || inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0) begin
        errors++;
        $display("FAIL lock_hold c=%0d req=%b addr=%h iaok=%b daok=%b want 1/500/0/0",
                 c, mem_req, mem_addr, inst_addr_ok, data_addr_ok);
      end
      tick();
    end
    mem_addr_ok = 1;
    settle();
    checks++;
    if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0 || mem_addr !== 32'h500) begin
      errors++;
      $display("FAIL lock_accept iaok=%b daok=%b addr=%h want 1/0/500", inst_addr_ok, data_addr_ok, mem_addr);
    end
    tick();
    inst_req = 0;
    settle();
    checks++;
    if (data_addr_ok !== 1'b1 || mem_addr !== 32'h600) begin
      errors++;
      $display("FAIL lock_release daok=%b addr=%h want 1/600", data_addr_ok, mem_addr);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_full();
    do_reset();
    inst_req = 1; mem_addr_ok = 1;
    for (int c = 0; c < 4; c++) begin
      inst_addr = 32'h700 + 32'(c * 4);
      settle();
      checks++;
      if (inst_addr_ok !== 1'b1) begin
        errors++;
        $display("FAIL full_fill c=%0d iaok=%b want 1", c, inst_addr_ok);
      end
      tick();
    end
    inst_addr = 32'h710;
    settle();
    checks++;
    if (mem_req !== 1'b0 || inst_addr_ok !== 1'b0) begin
      errors++;
      $display("FAIL full_block req=%b iaok=%b want 0/0", mem_req, inst_addr_ok);
    end
    tick();
    mem_data_ok = 1; mem_rdata = 32'h33;
    settle();
    checks++;
    if (mem_req !== 1'b0 || inst_data_ok !== 1'b1) begin
      errors++;
      $display("FAIL full_bubble req=%b iok=%b want 0/1", mem_req, inst_data_ok);
    end
    tick();
    mem_data_ok = 0;
    settle();
    checks++;
    if (mem_req !== 1'b1 || inst_addr_ok !== 1'b1 || mem_addr !== 32'h710) begin
      errors++;
      $display("FAIL full_resume req=%b iaok=%b addr=%h want 1/1/710", mem_req, inst_addr_ok, mem_addr);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_unexp_and_reset();
    do_reset();
    mem_data_ok = 1; mem_rdata = 32'h44;
    settle();
    checks++;
    if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0 || err_unexp_rsp !== 1'b0) begin
      errors++;
      $display("FAIL unexp_nopulse iok=%b dok=%b err=%b want 0/0/0", inst_data_ok, data_data_ok, err_unexp_rsp);
    end
    tick();
    mem_data_ok = 0;
    tick();
    checks++;
    if (err_unexp_rsp !== 1'b1) begin
      errors++;
      $display("FAIL unexp_sticky err=%b want 1", err_unexp_rsp);
    end
    inst_req = 1; inst_addr = 32'h800; mem_addr_ok = 1;
    tick();
    tick();
    mem_data_ok = 1;
    resetn = 0;
    #1;
    checks++;
    if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, err_unexp_rsp} !== 6'b0) begin
      errors++;
      $display("FAIL midburst_reset got=%b want 000000",
               {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, err_unexp_rsp});
    end
    tick();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
    resetn = 1;
    tick();
    mem_data_ok = 1;
    settle();
    checks++;
    if (inst_data_ok !== 1'b0) begin
      errors++;
      $display("FAIL stray_nopulse iok=%b want 0", inst_data_ok);
    end
    tick();
    mem_data_ok = 0;
    settle();
    checks++;
    if (err_unexp_rsp !== 1'b1) begin
      errors++;
      $display("FAIL stray_err err=%b want 1", err_unexp_rsp);
    end
    tick();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    resetn = 0;
    #1;
    test_reset();
    test_inst_reads();
    test_priority();
    test_round_robin();
    test_lock();
    test_full();
    test_unexp_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
